// File: rtl/axi_sdram_tgen_if.sv
// AXI4 write/read channel bundle between the traffic generator (master) and the SDRAM controller port (slave).
interface axi_sdram_tgen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arlen, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arlen, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_sdram_tgen.sv
// AXI4 INCR burst write/read-check generator, address-as-data pattern; TGEN_4K_CHECK_EN rejects 4 KiB crossings.
// Latency: AXI valid one cycle after accept; done/err one cycle after the B or final R handshake.
// Backpressure: cmd_ready only in IDLE; each AXI valid held until handshake; rready held high in RDATA.
module axi_sdram_tgen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  output logic                  done,
  output logic                  err,
  axi_sdram_tgen_if.master      m_axi
);
  localparam int BYTES = DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WRESP = 3'd3;
  localparam logic [2:0] S_RADDR = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wlast_q, wlast_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rerr_q, rerr_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  cross_4k;
  logic                  beat_err;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] base,
                                                    input logic [7:0] idx);
    logic [ADDR_WIDTH-1:0] a;
    a = base + ADDR_WIDTH'(idx) * ADDR_WIDTH'(BYTES);
    return DATA_WIDTH'(a);
  endfunction

`ifdef TGEN_4K_CHECK_EN
  logic [31:0] end_off;
  assign end_off  = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(BYTES);
  assign cross_4k = (end_off > 32'd4096);
`else
  assign cross_4k = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    wlast_d     = wlast_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rerr_d      = rerr_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cmd_ready_d = cmd_ready_q;
    beat_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          len_d       = cmd_len;
          cnt_d       = 8'd0;
          cmd_ready_d = 1'b0;
          if (cross_4k) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (cmd_write) begin
            state_d   = S_WADDR;
            awvalid_d = 1'b1;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WADDR: begin
        if (m_axi.m_axi_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wdata_d   = pattern(addr_q, 8'd0);
          wlast_d   = (len_q == 8'd0);
          state_d   = S_WDATA;
        end
      end
      S_WDATA: begin
        if (wvalid_q && m_axi.m_axi_wready) begin
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = S_WRESP;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            wdata_d = pattern(addr_q, cnt_d);
            wlast_d = (cnt_d == len_q);
          end
        end
      end
      S_WRESP: begin
        if (m_axi.m_axi_bvalid) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = |m_axi.m_axi_bresp;
          state_d  = S_FIN;
        end
      end
      S_RADDR: begin
        if (m_axi.m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          rerr_d    = 1'b0;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (m_axi.m_axi_rvalid) begin
          // A beat at index len without rlast means the burst has overrun its length.
          beat_err = (m_axi.m_axi_rdata != pattern(addr_q, cnt_q))
                   | (m_axi.m_axi_rlast && (cnt_q < len_q))
                   | (!m_axi.m_axi_rlast && (cnt_q >= len_q));
          cnt_d = cnt_q + 8'd1;
          if (m_axi.m_axi_rlast) begin
            rready_d = 1'b0;
            done_d   = 1'b1;
            err_d    = rerr_q | beat_err;
            state_d  = S_FIN;
          end else begin
            rerr_d = rerr_q | beat_err;
          end
        end
      end
      S_FIN: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rerr_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      wlast_q     <= wlast_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rerr_q      <= rerr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready           = cmd_ready_q;
  assign done                = done_q;
  assign err                 = err_q;
  assign m_axi.m_axi_awaddr  = addr_q;
  assign m_axi.m_axi_awlen   = len_q;
  assign m_axi.m_axi_awvalid = awvalid_q;
  assign m_axi.m_axi_wdata   = wdata_q;
  assign m_axi.m_axi_wlast   = wlast_q;
  assign m_axi.m_axi_wvalid  = wvalid_q;
  assign m_axi.m_axi_bready  = bready_q;
  assign m_axi.m_axi_araddr  = addr_q;
  assign m_axi.m_axi_arlen   = len_q;
  assign m_axi.m_axi_arvalid = arvalid_q;
  assign m_axi.m_axi_rready  = rready_q;
endmodule

// File: tb/tb_axi_sdram_tgen.sv
// Scoreboard bench: stimulus pushes expected AXI traffic and results; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_axi_sdram_tgen;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BYTES = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic          done;
  logic          err;

  axi_sdram_tgen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_sdram_tgen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .done(done), .err(err), .m_axi(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard queues (expected), slave plans and knobs
  int          exp_acc[$];
  logic [39:0] exp_aw[$];
  logic [39:0] exp_ar[$];
  logic [32:0] exp_w[$];
  logic        exp_done[$];
  logic [1:0]  bresp_q[$];
  logic [32:0] rplan[$];
  int          rdy_mode = 0;
  int          aw_stall = 0;
  int          pending_b = 0;
  int          w_hs_cnt = 0;
  bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;

  task automatic flush();
    exp_acc.delete(); exp_aw.delete(); exp_ar.delete(); exp_w.delete();
    exp_done.delete(); bresp_q.delete(); rplan.delete();
    pending_b = 0;
    aw_stall = 0;
  endtask

  // AXI slave responder: drives inputs 1ns after the rising edge
  initial begin : slave
    int  rc;
    bit  r_active;
    rc = 0;
    r_active = 0;
    bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_arready = 0;
    bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
    bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0; bus.m_axi_rlast = 0;
    forever begin
      @(posedge clk); #1;
      rc++;
      if (!rst_n) begin
        bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_arready = 0;
        bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
        bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0; bus.m_axi_rlast = 0;
        r_active = 0;
        continue;
      end
      case (rdy_mode)
        0: begin bus.m_axi_awready = 1; bus.m_axi_wready = 1; bus.m_axi_arready = 1; end
        1: begin
          bus.m_axi_awready = 1'($urandom_range(0, 1));
          bus.m_axi_wready  = 1'($urandom_range(0, 1));
          bus.m_axi_arready = 1'($urandom_range(0, 1));
        end
        default: begin bus.m_axi_awready = 1; bus.m_axi_wready = rc[0]; bus.m_axi_arready = 1; end
      endcase
      if (aw_stall > 0 && bus.m_axi_awvalid) begin
        bus.m_axi_awready = 0;
        aw_stall--;
      end
      if (hs_b) bus.m_axi_bvalid = 0;
      if (!bus.m_axi_bvalid && pending_b > 0 && bresp_q.size() > 0 &&
          (rdy_mode == 0 || $urandom_range(0, 1) == 1)) begin
        bus.m_axi_bvalid = 1;
        bus.m_axi_bresp  = bresp_q.pop_front();
        pending_b--;
      end
      if (hs_ar) r_active = 1;
      if (hs_r && rplan.size() > 0) void'(rplan.pop_front());
      if (rplan.size() == 0) r_active = 0;
      if (r_active && (rdy_mode == 0 || $urandom_range(0, 3) != 0)) begin
        bus.m_axi_rvalid = 1;
        {bus.m_axi_rlast, bus.m_axi_rdata} = rplan[0];
      end else begin
        bus.m_axi_rvalid = 0; bus.m_axi_rlast = 0; bus.m_axi_rdata = 0;
      end
    end
  end

  // Monitor: samples on the falling edge; handshakes seen here complete on the next rising edge
  initial begin : monitor
    int          acc_pend;
    bit          done_pend, post_done, w_start, w_end;
    bit          p_awv, p_wv, p_arv, p_hs_aw, p_hs_w, p_hs_ar;
    logic [40:0] p_aw, p_ar;
    logic [32:0] p_w;
    logic [39:0] e40;
    logic [32:0] e33;
    acc_pend = -1;
    {done_pend, post_done, w_start, w_end} = '0;
    {p_awv, p_wv, p_arv, p_hs_aw, p_hs_w, p_hs_ar} = '0;
    p_aw = '0; p_ar = '0; p_w = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_pend = -1;
        {done_pend, post_done, w_start, w_end} = '0;
        {p_awv, p_wv, p_arv, p_hs_aw, p_hs_w, p_hs_ar} = '0;
        {hs_aw, hs_w, hs_b, hs_ar, hs_r} = '0;
        continue;
      end
      if (acc_pend >= 0) begin
        check("acc_cmd_ready", cmd_ready, 0);
        check("acc_awvalid", bus.m_axi_awvalid, acc_pend == 0);
        check("acc_arvalid", bus.m_axi_arvalid, acc_pend == 1);
        check("acc_done", done, acc_pend == 2);
      end
      if (done_pend) check("done_latency", done, 1);
      if (post_done) begin
        check("done_pulse", done, 0);
        check("ready_after_fin", cmd_ready, 1);
      end
      if (w_start) check("wvalid_after_aw", bus.m_axi_wvalid, 1);
      if (w_end) begin
        check("wvalid_after_last", bus.m_axi_wvalid, 0);
        check("bready_after_last", bus.m_axi_bready, 1);
      end
      if (p_awv && !p_hs_aw)
        check("aw_hold", {bus.m_axi_awvalid, bus.m_axi_awlen, bus.m_axi_awaddr}, p_aw);
      if (p_wv && !p_hs_w)
        check("w_hold", {bus.m_axi_wvalid, bus.m_axi_wlast, bus.m_axi_wdata}, {1'b1, p_w});
      if (p_arv && !p_hs_ar)
        check("ar_hold", {bus.m_axi_arvalid, bus.m_axi_arlen, bus.m_axi_araddr}, p_ar);

      post_done = 0;
      if (done) begin
        if (exp_done.size() == 0) check("done_unexpected", done, 0);
        else begin
          check("err", err, exp_done.pop_front());
          check("w_beats_left", exp_w.size(), 0);
        end
        post_done = 1;
      end

      acc_pend = -1;
      if (cmd_valid && cmd_ready) begin
        if (exp_acc.size() == 0) check("accept_unexpected", cmd_ready, 0);
        else acc_pend = exp_acc.pop_front();
      end
      hs_aw = bus.m_axi_awvalid & bus.m_axi_awready;
      hs_w  = bus.m_axi_wvalid & bus.m_axi_wready;
      hs_b  = bus.m_axi_bvalid & bus.m_axi_bready;
      hs_ar = bus.m_axi_arvalid & bus.m_axi_arready;
      hs_r  = bus.m_axi_rvalid & bus.m_axi_rready;
      if (hs_aw) begin
        if (exp_aw.size() == 0) check("aw_unexpected", hs_aw, 0);
        else begin e40 = exp_aw.pop_front(); check("aw_addr_len", {bus.m_axi_awlen, bus.m_axi_awaddr}, e40); end
      end
      if (hs_w) begin
        w_hs_cnt++;
        if (exp_w.size() == 0) check("w_unexpected", hs_w, 0);
        else begin e33 = exp_w.pop_front(); check("w_beat", {bus.m_axi_wlast, bus.m_axi_wdata}, e33); end
        if (bus.m_axi_wlast) pending_b++;
      end
      if (hs_ar) begin
        if (exp_ar.size() == 0) check("ar_unexpected", hs_ar, 0);
        else begin e40 = exp_ar.pop_front(); check("ar_addr_len", {bus.m_axi_arlen, bus.m_axi_araddr}, e40); end
      end
      done_pend = hs_b | (hs_r & bus.m_axi_rlast);
      w_start = hs_aw;
      w_end   = hs_w & bus.m_axi_wlast;
      p_awv = bus.m_axi_awvalid; p_hs_aw = hs_aw;
      p_wv  = bus.m_axi_wvalid;  p_hs_w  = hs_w;
      p_arv = bus.m_axi_arvalid; p_hs_ar = hs_ar;
      p_aw = {bus.m_axi_awvalid, bus.m_axi_awlen, bus.m_axi_awaddr};
      p_ar = {bus.m_axi_arvalid, bus.m_axi_arlen, bus.m_axi_araddr};
      p_w  = {bus.m_axi_wlast, bus.m_axi_wdata};
    end
  end

  // Reference model: expected traffic and result derived from the command and the slave's plan
  task automatic push_expect(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] bresp, input int bad_idx, input int last_idx);
    bit          rej;
    bit          e;
    logic [31:0] p, d;
    rej = 0;
`ifdef TGEN_4K_CHECK_EN
    rej = (int'(addr[11:0]) + (int'(len) + 1) * BYTES) > 4096;
`endif
    if (rej) begin
      exp_acc.push_back(2);
      exp_done.push_back(1'b1);
    end else if (wr) begin
      exp_acc.push_back(0);
      exp_aw.push_back({len, addr});
      for (int i = 0; i <= int'(len); i++)
        exp_w.push_back({(i == int'(len)), addr + 32'(i * BYTES)});
      bresp_q.push_back(bresp);
      exp_done.push_back(bresp != 2'd0);
    end else begin
      exp_acc.push_back(1);
      exp_ar.push_back({len, addr});
      e = (last_idx != int'(len));
      for (int i = 0; i <= last_idx; i++) begin
        p = addr + 32'(i * BYTES);
        d = (i == bad_idx) ? 32'hDEADBEEF : p;
        if (d != p) e = 1;
        rplan.push_back({(i == last_idx), d});
      end
      exp_done.push_back(e);
    end
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [7:0] len, input bit poke);
    for (int t = 0; t < 500 && !cmd_ready; t++) begin @(posedge clk); #1; end
    if (!cmd_ready) check("cmd_ready_timeout", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_addr = $urandom; cmd_len = 8'($urandom);
    if (poke) begin
      @(posedge clk); #1;
      cmd_valid = 1; cmd_write = ~wr;
      @(posedge clk); #1;
      cmd_valid = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_awvalid", bus.m_axi_awvalid, 0);
    check("rst_wvalid", bus.m_axi_wvalid, 0);
    check("rst_bready", bus.m_axi_bready, 0);
    check("rst_arvalid", bus.m_axi_arvalid, 0);
    check("rst_rready", bus.m_axi_rready, 0);
    check("rst_addr_len", {bus.m_axi_awlen, bus.m_axi_awaddr, bus.m_axi_araddr}, 0);
    check("rst_wdata", {bus.m_axi_wlast, bus.m_axi_wdata}, 0);
    flush();
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    #1 check("ready_before_edge", cmd_ready, 0);
    @(posedge clk); #1;
    check("ready_after_release", cmd_ready, 1);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 3000 && exp_done.size() != 0; t++) @(posedge clk);
    if (exp_done.size() != 0) begin
      check("done_timeout", exp_done.size(), 0);
      do_reset();
    end
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] bresp, input int bad_idx, input int last_idx, input bit poke);
    push_expect(wr, addr, len, bresp, bad_idx, last_idx);
    issue(wr, addr, len, poke);
    wait_done();
  endtask

  initial begin : stim
    int start;
    bit          wr;
    logic [31:0] a;
    logic [7:0]  l;
    logic [1:0]  br;
    int          bad, last;
    do_reset();
    rdy_mode = 0;
    run_cmd(1, 32'h100, 8'd3, 2'd0, -1, 3, 0);
    rdy_mode = 2; aw_stall = 3;
    run_cmd(1, 32'h100, 8'd3, 2'd0, -1, 3, 0);
    rdy_mode = 0;
    run_cmd(0, 32'h100, 8'd3, 2'd0, -1, 3, 0);
    run_cmd(0, 32'h100, 8'd3, 2'd0, 2, 3, 0);
    run_cmd(1, 32'h100, 8'd3, 2'd2, -1, 3, 0);
    run_cmd(0, 32'h100, 8'd3, 2'd0, -1, 1, 1);
    run_cmd(0, 32'h240, 8'd1, 2'd0, -1, 3, 0);
    run_cmd(1, 32'h000, 8'd0, 2'd0, -1, 0, 0);
    run_cmd(1, 32'hFF8, 8'd3, 2'd0, -1, 3, 0);

    // Reset abandons a write after two accepted beats; the next commands run cleanly
    push_expect(1, 32'h300, 8'd7, 2'd0, -1, 7);
    start = w_hs_cnt;
    issue(1, 32'h300, 8'd7, 0);
    for (int t = 0; t < 100 && w_hs_cnt < start + 2; t++) begin @(negedge clk); #1; end
    check("beats_before_reset", w_hs_cnt - start, 2);
    do_reset();
    run_cmd(1, 32'h200, 8'd1, 2'd0, -1, 1, 0);
    run_cmd(0, 32'h200, 8'd1, 2'd0, -1, 1, 0);

    rdy_mode = 1;
    for (int k = 0; k < 30; k++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = 32'($urandom_range(0, 16383)) << 2;
      l    = 8'($urandom_range(0, 15));
      br   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l))) : -1;
      last = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(l) + 2)) : int'(l);
      run_cmd(wr, a, l, br, bad, last, 0);
    end
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end
endmodule

// File: doc/axi_sdram_tgen.md
# axi_sdram_tgen
AXI4 burst initiator that drives the SDRAM controller's AXI slave port for bring-up and regression. It accepts one command at a time (write or read, start address, beat count). Write commands issue an INCR burst with an address-as-data pattern. Read commands issue a burst, check every returned beat against the same pattern, and report pass or fail on a one-cycle `done` pulse.
## Interface
- `ADDR_WIDTH`, 32, AXI address width; also the width of `cmd_addr`.
- `DATA_WIDTH`, 32, AXI data width; byte lanes `BYTES = DATA_WIDTH/8`, power of two, ≥ 2.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE; command accepted on `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write burst, 0 = read-and-check burst.
- `cmd_addr`  in  ADDR_WIDTH  burst start byte address, `BYTES`-aligned.
- `cmd_len`  in  8  beats minus 1 (AXI len encoding).
- `done`  out  1  one-cycle pulse at the end of each command.
- `err`  out  1  result of the last command; updated with `done` and held until the next `done`.
- `m_axi_awaddr`  out  ADDR_WIDTH  latched `cmd_addr`.
- `m_axi_awlen`  out  8  latched `cmd_len`.
- `m_axi_awvalid`  out  1  write address valid.
- `m_axi_awready`  in  1  write address ready.
- `m_axi_wdata`  out  DATA_WIDTH  pattern beat.
- `m_axi_wlast`  out  1  high on beat index == len.
- `m_axi_wvalid`  out  1  write data valid.
- `m_axi_wready`  in  1  write data ready.
- `m_axi_bresp`  in  2  write response code.
- `m_axi_bvalid`  in  1  write response valid.
- `m_axi_bready`  out  1  write response ready.
- `m_axi_araddr`  out  ADDR_WIDTH  latched `cmd_addr`.
- `m_axi_arlen`  out  8  latched `cmd_len`.
- `m_axi_arvalid`  out  1  read address valid.
- `m_axi_arready`  in  1  read address ready.
- `m_axi_rdata`  in  DATA_WIDTH  read data.
- `m_axi_rlast`  in  1  last read beat.
- `m_axi_rvalid`  in  1  read data valid.
- `m_axi_rready`  out  1  read data ready.
## Operation
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, FIN. Transitions:
  - IDLE → WADDR or RADDR on accept.
  - WADDR → WDATA on AW handshake; WDATA → WRESP on the last W handshake; WRESP → FIN on B handshake.
  - RADDR → RDATA on AR handshake; RDATA → FIN on the R handshake carrying `rlast`.
  - FIN → IDLE.
- Size and burst type are not outputs; INCR at full width (`BYTES` per beat) is implied and tied off at the top level.
- Pattern: beat i = low DATA_WIDTH bits of `addr + i*BYTES`. Beat counter is 8 bits wide and is cleared on accept.
- Write burst: `err` = (`bresp` != 0).
- Read burst `err` is a sticky OR of:
  - any beat whose data differs from its pattern;
  - `rlast` on a beat with index < len;
  - index > len reached without `rlast`. The counter wraps at 255. The burst ends only on `rlast`.
- `cmd_valid` outside IDLE is ignored; no queueing.
- Async reset (`rst` low) puts the block in IDLE and immediately drives every output to 0 (valids, `bready`, `rready`, `done`, `err`, `cmd_ready`, address/len/data). An in-flight burst is abandoned.
## Timing
- All outputs are registered. After reset release, `cmd_ready` rises on the first clock edge.
- Accept at edge N: `awvalid`/`arvalid` high and `cmd_ready` low from N+1. Each valid is held until its handshake.
- AW handshake at edge M: `wvalid` high with beat 0 from M+1. `wdata`/`wlast` stay stable while `wvalid & !wready`; after a handshake the next beat appears in the following cycle.
- Last W handshake at edge L: `wvalid` 0 and `bready` 1 from L+1. B handshake at edge K: `done`=1 and `err` valid during K+1; `cmd_ready`=1 from K+2.
- `rready` is high for the whole RDATA state, so the block accepts one beat per cycle. `rlast` handshake at edge R: `done`/`err` during R+1.
## Configuration
- `TGEN_4K_CHECK_EN` defined: a command with `cmd_addr[11:0] + (cmd_len+1)*BYTES > 4096` is rejected.
  - Reject at accept edge N: no AXI traffic, FIN during N+1 with `done`=1 and `err`=1.
- `TGEN_4K_CHECK_EN` undefined: no check; every command is issued as given.
## Test plan
- Write 0x100, len 3, all readies 1 → `awaddr`=0x100, `awlen`=3; `wdata` 0x100/0x104/0x108/0x10C, `wlast` on beat 4; `bresp`=0 → `done`, `err`=0.
- Same write with `wready` alternating 1/0 → `wdata` stable across stalls, exactly 4 handshakes; `awvalid` held through 3 cycles of `awready`=0.
- Read 0x100, len 3, correct data → `err`=0; repeat with beat 2 = 0xDEADBEEF → `err`=1; `bresp`=2 on a write → `err`=1.
- Read len 3 with `rlast` on beat 1 → `done` the cycle after that beat, `err`=1; `cmd_valid` pulsed mid-burst → ignored.
- Macro on: write 0xFF8, len 3 → no `awvalid`, `done` at N+1 with `err`=1. Macro off: `awaddr`=0xFF8 issued.
- `rst` low after 2 W beats → `wvalid`/`bready` 0 asynchronously; `cmd_ready`=1 one edge after release; the next command runs cleanly.
